mem_data_ctrl: RTL and testbench
================================

MEM_DATA_CTRL -- requirements
Module: mem_data_ctrl

Interface
REQ-001 The block SHALL have these ports, clock and reset first: clk in 1, system clock; resetn in 1, reset (synchronous, active-low).
REQ-002 The block SHALL have these pipeline-side inputs:
- mem_valid in 1, MEM stage holds a valid instruction.
- mem_load in 1, load instruction.
- mem_store in 1, store instruction.
- mem_size in 2, access size: 0 byte, 1 half, 2 word.
- mem_addr in 32, effective address.
- mem_wdata in 32, store data (low-aligned).
- mem_ex in 1, instruction already carries an exception.
- refresh in 1, pipeline flush.
- stall_in in 1, downstream stage is not accepting.
REQ-003 The block SHALL have these SRAM-like data port signals:
- data_req out 1, request.
- data_wr out 1, write.
- data_size out 2, access size.
- data_addr out 32, address.
- data_wstrb out 4, byte strobes.
- data_wdata out 32, write data.
- data_addr_ok in 1, address accepted.
- data_data_ok in 1, data returned or write complete.
- data_rdata in 32, read data.
REQ-004 The block SHALL have these pipeline-side outputs:
- mem_rdata out 32, raw loaded word to MEM/WB register.
- mem_stall out 1, hold the MEM stage.
- addr_err out 1, misaligned access (combinational).

Function
REQ-005 The block SHALL assert addr_err when mem_valid & (mem_load|mem_store) and either size=1 with addr[0]=1 or size=2 with addr[1:0]!=0.
REQ-006 access SHALL be mem_valid & (mem_load|mem_store) & !mem_ex & !addr_err & !refresh.
REQ-007 The block SHALL implement a state machine with states IDLE, REQ, WAIT, DONE and DISCARD.
REQ-008 In IDLE with access, data_req SHALL be 1 combinationally, the fields SHALL be driven from the inputs, and the fields SHALL be latched into request registers.
- Transition to WAIT if data_addr_ok=1, else to REQ.
REQ-009 In REQ, data_req SHALL stay 1 with the latched fields unchanged until data_addr_ok.
- On data_addr_ok, transition to WAIT, or to DISCARD if refresh was seen since issue.
REQ-010 In WAIT, on data_data_ok the block SHALL latch data_rdata into mem_rdata and transition to DONE.
- If refresh=1 without data_data_ok, transition to DISCARD.
- If refresh=1 with data_data_ok in the same cycle, transition to IDLE and leave mem_rdata unchanged.
REQ-011 In DONE, the block SHALL stay while stall_in=1 and return to IDLE when stall_in=0 or refresh=1.
REQ-012 In DISCARD, the block SHALL wait for data_data_ok, drop the data, and return to IDLE.
- No new request SHALL be issued in DISCARD.
REQ-013 mem_stall SHALL be 1 in the following cases:
- IDLE with access.
- REQ and WAIT, except when refresh=1.
- DISCARD while mem_valid & (mem_load|mem_store).
REQ-014 mem_stall SHALL be 0 in DONE.
REQ-015 data_wr SHALL equal mem_store; data_size SHALL equal mem_size.
REQ-016 data_wstrb SHALL follow the access size:
- byte: 1 << addr[1:0].
- half: addr[1] ? 1100 : 0011.
- word: 1111.
- loads: 0000.
REQ-017 data_wdata SHALL be the store data replicated across the word:
- byte: {4{wdata[7:0]}}.
- half: {2{wdata[15:0]}}.
- word: wdata.
REQ-018 When data_req=0, data_wr, data_size, data_addr, data_wstrb and data_wdata SHALL be 0.
REQ-019 Only one request SHALL be outstanding; the block SHALL not issue a new request before the prior data_data_ok.
REQ-020 Minimum load latency SHALL be 2 cycles: request with addr_ok in cycle 0, data_ok in cycle 1, DONE in cycle 2, mem_stall high in cycles 0-1.
REQ-021 Stores SHALL use the same sequence; mem_rdata SHALL be left unchanged on store completion.

Reset
REQ-022 When resetn=0 at a clk edge, the state SHALL go to IDLE and mem_rdata and the request registers SHALL go to 0.
REQ-023 During reset, data_req and mem_stall SHALL be 0.
REQ-024 Reset SHALL abandon any outstanding transaction without waiting for data_data_ok.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Load word, addr 0x1000, addr_ok in cycle 0, data_ok with 0xDEADBEEF in cycle 1 -> mem_rdata=0xDEADBEEF in cycle 2; mem_stall high in cycles 0-1 only.
- Store byte, addr 0x1003, wdata 0x000000A5 -> data_wstrb=1000, data_wdata=0xA5A5A5A5, data_wr=1.
- Load half at 0x1001 -> addr_err=1, data_req=0, mem_stall=0.
- addr_ok withheld 3 cycles -> data_req and data_addr held stable all 3 cycles, then WAIT.
- refresh during WAIT, data_ok 2 cycles later, with a new load presented -> the new load's data_req is issued only after the discarded data_ok; mem_rdata unchanged by the discarded data.
- Load completes while stall_in=1 for 2 cycles -> the block stays in DONE, mem_rdata stable, no new request.

Source files
------------

// File: rtl/mem_data_ctrl.sv
// rtl/mem_data_ctrl.sv - MEM-stage data port controller bridging the pipeline to an SRAM-like bus
module mem_data_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_ex,
  input  logic        refresh,
  input  logic        stall_in,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        addr_err
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DISCARD} state_t;

  state_t      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_wr_q, req_wr_d;
  logic [1:0]  req_size_q, req_size_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [3:0]  req_wstrb_q, req_wstrb_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic        flush_seen_q, flush_seen_d;

  logic        mem_op;
  logic        access;
  logic [3:0]  wstrb_in;
  logic [31:0] wdata_in;

  assign mem_op    = mem_valid & (mem_load | mem_store);
  assign access    = mem_op & ~mem_ex & ~addr_err & ~refresh;
  assign mem_rdata = rdata_q;

  // Flag half/word accesses that are not naturally aligned
  always_comb begin
    addr_err = 1'b0;
    if (mem_op) begin
      if (mem_size == 2'd1 && mem_addr[0]) begin
        addr_err = 1'b1;
      end else if (mem_size == 2'd2 && mem_addr[1:0] != 2'b00) begin
        addr_err = 1'b1;
      end
    end
  end

  // Byte strobes and replicated write data derived from the access size
  always_comb begin
    wstrb_in = 4'b0000;
    wdata_in = mem_wdata;
    case (mem_size)
      2'd0: begin
        wstrb_in = 4'b0001 << mem_addr[1:0];
        wdata_in = {4{mem_wdata[7:0]}};
      end
      2'd1: begin
        wstrb_in = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{mem_wdata[15:0]}};
      end
      default: begin
        wstrb_in = 4'b1111;
        wdata_in = mem_wdata;
      end
    endcase
    if (!mem_store) begin
      wstrb_in = 4'b0000;
    end
  end

  // Transaction sequencing, bus outputs and pipeline stall
  always_comb begin
    state_d      = state_q;
    rdata_d      = rdata_q;
    req_wr_d     = req_wr_q;
    req_size_d   = req_size_q;
    req_addr_d   = req_addr_q;
    req_wstrb_d  = req_wstrb_q;
    req_wdata_d  = req_wdata_q;
    flush_seen_d = flush_seen_q;
    data_req     = 1'b0;
    data_wr      = 1'b0;
    data_size    = 2'd0;
    data_addr    = 32'd0;
    data_wstrb   = 4'd0;
    data_wdata   = 32'd0;
    mem_stall    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          data_req     = 1'b1;
          data_wr      = mem_store;
          data_size    = mem_size;
          data_addr    = mem_addr;
          data_wstrb   = wstrb_in;
          data_wdata   = wdata_in;
          mem_stall    = 1'b1;
          req_wr_d     = mem_store;
          req_size_d   = mem_size;
          req_addr_d   = mem_addr;
          req_wstrb_d  = wstrb_in;
          req_wdata_d  = wdata_in;
          flush_seen_d = 1'b0;
          state_d      = data_addr_ok ? S_WAIT : S_REQ;
        end
      end
      S_REQ: begin
        // The bus request cannot be withdrawn, so a flush is remembered and
        // the eventual response is dropped.
        data_req   = 1'b1;
        data_wr    = req_wr_q;
        data_size  = req_size_q;
        data_addr  = req_addr_q;
        data_wstrb = req_wstrb_q;
        data_wdata = req_wdata_q;
        mem_stall  = ~refresh;
        if (refresh) begin
          flush_seen_d = 1'b1;
        end
        if (data_addr_ok) begin
          state_d = (flush_seen_q | refresh) ? S_DISCARD : S_WAIT;
        end
      end
      S_WAIT: begin
        mem_stall = ~refresh;
        if (data_data_ok) begin
          state_d = refresh ? S_IDLE : S_DONE;
          if (!refresh && !req_wr_q) begin
            rdata_d = data_rdata;
          end
        end else if (refresh) begin
          state_d = S_DISCARD;
        end
      end
      S_DONE: begin
        if (!stall_in || refresh) begin
          state_d = S_IDLE;
        end
      end
      S_DISCARD: begin
        mem_stall = mem_op;
        if (data_data_ok) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (!resetn) begin
      data_req   = 1'b0;
      data_wr    = 1'b0;
      data_size  = 2'd0;
      data_addr  = 32'd0;
      data_wstrb = 4'd0;
      data_wdata = 32'd0;
      mem_stall  = 1'b0;
    end
  end

  // State, loaded data and request registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      rdata_q      <= 32'd0;
      req_wr_q     <= 1'b0;
      req_size_q   <= 2'd0;
      req_addr_q   <= 32'd0;
      req_wstrb_q  <= 4'd0;
      req_wdata_q  <= 32'd0;
      flush_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rdata_q      <= rdata_d;
      req_wr_q     <= req_wr_d;
      req_size_q   <= req_size_d;
      req_addr_q   <= req_addr_d;
      req_wstrb_q  <= req_wstrb_d;
      req_wdata_q  <= req_wdata_d;
      flush_seen_q <= flush_seen_d;
    end
  end

endmodule

// File: tb/tb_mem_data_ctrl.sv
// tb/tb_mem_data_ctrl.sv - scoreboard bench for mem_data_ctrl with a byte-level memory model
module tb_mem_data_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0, mem_load = 1'b0, mem_store = 1'b0;
  logic [1:0]  mem_size = 2'd0;
  logic [31:0] mem_addr = 32'd0, mem_wdata = 32'd0;
  logic        mem_ex = 1'b0, refresh = 1'b0, stall_in = 1'b0;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
  logic [31:0] data_rdata = 32'd0;
  logic [31:0] mem_rdata;
  logic        mem_stall, addr_err;

  mem_data_ctrl dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_load(mem_load), .mem_store(mem_store),
    .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ex(mem_ex), .refresh(refresh), .stall_in(stall_in),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;
  typedef struct {
    bit          is_load;
    logic [31:0] val;
  } rd_t;

  req_t        req_q[$];
  rd_t         rd_q[$];
  logic [7:0]  ref_mem [256];
  logic [31:0] resp_mem [64];
  logic [31:0] exp_rdata = 32'd0;
  bit          exp_err, exp_acc;
  int          n_tests = 0, n_fail = 0;
  int          directed = 1, dir_hold = 0, dir_lat = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one MEM-stage instruction and record what the bus and mem_rdata must show
  task automatic present(input bit ld, input bit st, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input bit ex);
    int nb;
    req_t r;
    rd_t d;
    mem_valid = 1'b1; mem_load = ld; mem_store = st; mem_size = sz;
    mem_addr = a; mem_wdata = wd; mem_ex = ex;
    nb = 1 << sz;
    exp_err = (ld || st) && ((a % nb) != 0);
    exp_acc = (ld || st) && !exp_err && !ex;
    if (exp_acc) begin
      r.wr = st; r.size = sz; r.addr = a; r.wstrb = 4'd0; r.wdata = 32'd0;
      for (int i = 0; i < 4; i++) begin
        r.wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
        if (st && i >= int'(a[1:0]) && i < int'(a[1:0]) + nb) r.wstrb[i] = 1'b1;
      end
      req_q.push_back(r);
      d.is_load = ld;
      d.val = 32'd0;
      if (ld) for (int i = 0; i < 4; i++) d.val[8*i +: 8] = ref_mem[{a[7:2], 2'b00} + i];
      if (st) for (int k = 0; k < nb; k++) ref_mem[a[7:0] + k] = wd[8*k +: 8];
      rd_q.push_back(d);
    end
  endtask

  // Wait until the pipeline may advance, optionally holding stall_in for extra cycles
  task automatic finish(input int extra, output int stall_cycles);
    int budget;
    int ex2;
    budget = 0;
    ex2 = extra;
    stall_cycles = 0;
    @(negedge clk);
    chk("addr_err", addr_err, exp_err);
    if (!exp_acc) begin
      chk("noacc_req", data_req, 1'b0);
      chk("noacc_stall", mem_stall, 1'b0);
    end
    forever begin
      if (mem_stall) stall_cycles++;
      else if (stall_in) begin
        chk("held_no_req", data_req, 1'b0);
        chk("held_rdata", mem_rdata, exp_rdata);
      end
      if (!mem_stall) begin
        if (ex2 > 0) begin
          stall_in = 1'b1;
          ex2--;
        end else begin
          stall_in = 1'b0;
          break;
        end
      end
      budget++;
      if (budget > 60) begin
        n_tests++; n_fail++;
        $display("FAIL timeout: mem_stall still %0d after %0d cycles, required 0", mem_stall, budget);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  // SRAM-like responder: word memory written through the strobes
  bit          pending = 0, in_req = 0, p_load = 0;
  int          hold = 0, wait_cnt = 0;
  logic [5:0]  p_idx = 6'd0;
  initial begin
    forever begin
      @(negedge clk);
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata = $urandom;
      if (!resetn) begin
        pending = 0;
        in_req = 0;
        continue;
      end
      if (pending) begin
        if (wait_cnt == 0) begin
          data_data_ok = 1'b1;
          if (p_load) data_rdata = resp_mem[p_idx];
          pending = 0;
        end else begin
          wait_cnt--;
        end
      end else if (data_req) begin
        if (!in_req) begin
          in_req = 1;
          hold = directed ? dir_hold : $urandom_range(0, 2);
        end
        if (hold == 0) begin
          data_addr_ok = 1'b1;
          in_req = 0;
          pending = 1;
          wait_cnt = directed ? dir_lat : $urandom_range(0, 2);
          p_load = !data_wr;
          p_idx = data_addr[7:2];
          if (data_wr) begin
            for (int i = 0; i < 4; i++)
              if (data_wstrb[i]) resp_mem[p_idx][8*i +: 8] = data_wdata[8*i +: 8];
          end
        end else begin
          hold--;
        end
      end
    end
  end

  // Monitor: checks accepted requests and the mem_rdata that follows each data_ok
  bit   chk_next = 0;
  req_t mr;
  rd_t  md;
  initial begin
    forever begin
      @(negedge clk); #1;
      if (chk_next) begin
        chk_next = 0;
        if (rd_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rd_unexpected: data_ok with no expected result, mem_rdata 0x%08h", mem_rdata);
        end else begin
          md = rd_q.pop_front();
          if (md.is_load) exp_rdata = md.val;
          chk("mem_rdata", mem_rdata, exp_rdata);
        end
      end
      if (data_data_ok && resetn) chk_next = 1;
      if (data_req && data_addr_ok) begin
        if (req_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL req_unexpected: request at 0x%08h, required none", data_addr);
        end else begin
          mr = req_q.pop_front();
          chk("req_wr", data_wr, mr.wr);
          chk("req_size", data_size, mr.size);
          chk("req_addr", data_addr, mr.addr);
          chk("req_wstrb", data_wstrb, mr.wstrb);
          chk("req_wdata", data_wdata, mr.wdata);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] w, a;
  logic [1:0]  sz;
  int          sc, op;
  initial begin
    for (int i = 0; i < 64; i++) begin
      w = (i == 0) ? 32'hDEADBEEF : $urandom;
      resp_mem[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end
    // Reset with a load presented: nothing may be requested
    mem_valid = 1'b1; mem_load = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req", data_req, 1'b0);
    chk("rst_stall", mem_stall, 1'b0);
    chk("rst_rdata", mem_rdata, 32'd0);
    mem_valid = 1'b0; mem_load = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;

    // Minimum-latency load word
    dir_hold = 0; dir_lat = 0;
    present(1, 0, 2'd2, 32'h1000, 32'd0, 0);
    finish(0, sc);
    chk("lat_stall_cycles", sc, 2);
    chk("lat_rdata", mem_rdata, 32'hDEADBEEF);

    // Store byte at the top lane
    present(0, 1, 2'd0, 32'h1003, 32'h000000A5, 0);
    #2;
    chk("sb_wstrb", data_wstrb, 4'b1000);
    chk("sb_wdata", data_wdata, 32'hA5A5A5A5);
    chk("sb_wr", data_wr, 1'b1);
    finish(0, sc);

    // Misaligned half load
    present(1, 0, 2'd1, 32'h1001, 32'd0, 0);
    #2;
    chk("mis_err", addr_err, 1'b1);
    chk("mis_req", data_req, 1'b0);
    chk("mis_stall", mem_stall, 1'b0);
    finish(0, sc);

    // addr_ok withheld for three cycles
    dir_hold = 3; dir_lat = 0;
    present(1, 0, 2'd2, 32'h1004, 32'd0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold_req", data_req, 1'b1);
      chk("hold_addr", data_addr, 32'h1004);
    end
    @(negedge clk);
    chk("hold_wait_req", data_req, 1'b0);
    chk("hold_wait_stall", mem_stall, 1'b1);
    @(posedge clk); #1;
    finish(0, sc);

    // Flush during WAIT; the next load waits for the discarded response
    dir_hold = 0; dir_lat = 2;
    present(1, 0, 2'd2, 32'h1008, 32'd0, 0);
    rd_q[rd_q.size() - 1].is_load = 0;
    @(negedge clk);
    chk("fl_a_req", data_req, 1'b1);
    @(posedge clk); #1;
    refresh = 1'b1;
    #2;
    chk("fl_stall", mem_stall, 1'b0);
    @(posedge clk); #1;
    refresh = 1'b0;
    present(1, 0, 2'd2, 32'h100C, 32'd0, 0);
    @(negedge clk);
    chk("fl_disc_req0", data_req, 1'b0);
    chk("fl_disc_stall", mem_stall, 1'b1);
    @(negedge clk);
    chk("fl_disc_req1", data_req, 1'b0);
    @(negedge clk);
    chk("fl_b_req", data_req, 1'b1);
    @(posedge clk); #1;
    finish(0, sc);

    // Load completes while downstream holds for two cycles
    dir_hold = 0; dir_lat = 0;
    present(1, 0, 2'd2, 32'h1010, 32'd0, 0);
    finish(2, sc);

    // Reset abandons an outstanding load
    dir_lat = 3;
    present(1, 0, 2'd2, 32'h1014, 32'd0, 0);
    @(negedge clk);
    @(posedge clk); #1;
    resetn = 1'b0;
    #2;
    chk("ra_req", data_req, 1'b0);
    chk("ra_stall", mem_stall, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b1;
    rd_q.delete();
    exp_rdata = 32'd0;
    #2;
    chk("ra_rdata", mem_rdata, 32'd0);
    dir_lat = 0;
    present(1, 0, 2'd2, 32'h1014, 32'd0, 0);
    finish(0, sc);

    // Randomized mix of loads, stores, bubbles, exceptions and misalignment
    directed = 0;
    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 2));
      a = 32'h1000 + $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      present(op == 0, op == 1, sz, a, $urandom, $urandom_range(0, 9) == 0);
      finish($urandom_range(0, 2), sc);
    end
    mem_valid = 1'b0; mem_load = 1'b0; mem_store = 1'b0;
    repeat (4) @(negedge clk);
    chk("req_q_empty", req_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
